// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: a latched 128-bit state is mixed in
// place, COLS_PER_CYCLE columns per clock, between two valid/ready handshakes.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int FIXED_MODE     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // col_idx advances by COLS_PER_CYCLE and wraps; the pass that starts at
    // LAST_IDX is the one that mixes column 3.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
        if (FIXED_MODE < 0 || FIXED_MODE > 2) begin : g_bad_mode
            $error("mix_columns_engine: FIXED_MODE must be 0, 1 or 2");
        end
    endgenerate

    logic [1:0]   state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic         mode_q, mode_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column c sits at bits [(3-c)*32 +: 32]; 3-c is ~c for a 2-bit index.
    function automatic logic [6:0] col_lsb(input logic [1:0] c);
        return {~c, 5'b00000};
    endfunction

    // Inverse mixing is the forward matrix applied after a {05,00,04,00}
    // circulant pre-pass, so both modes share the forward datapath.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3, u, v, t;
        {a0, a1, a2, a3} = col;
        u = xt(xt(a0 ^ a2));
        v = xt(xt(a1 ^ a3));
        if (inv) begin
            a0 = a0 ^ u;
            a1 = a1 ^ v;
            a2 = a2 ^ u;
            a3 = a3 ^ v;
        end
        t = a0 ^ a1 ^ a2 ^ a3;
        return {a0 ^ t ^ xt(a0 ^ a1), a1 ^ t ^ xt(a1 ^ a2),
                a2 ^ t ^ xt(a2 ^ a3), a3 ^ t ^ xt(a3 ^ a0)};
    endfunction

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        col_idx_d = col_idx_q;
        mode_d    = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d    = in_state;
                    mode_d    = (FIXED_MODE == 2) ? in_inv : (FIXED_MODE == 1);
                    col_idx_d = 2'd0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    work_d[col_lsb(col_idx_q + 2'(i)) +: 32] =
                        mix_col(work_q[col_lsb(col_idx_q + 2'(i)) +: 32], mode_q);
                end
                col_idx_d = col_idx_q + COL_STEP;
                if (col_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            col_idx_q <= 2'd0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            col_idx_q <= col_idx_d;
            mode_q    <= mode_d;
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. in_ready/out_valid are state decodes only; out_ready
    // influences nothing but the DONE->IDLE step.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_state = work_q;

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Sequential, handshaked AES MixColumns / InvMixColumns engine that generalises the combinational inverse-only column mixer.
- Mode is selectable per block (forward or inverse), either at run time or fixed by parameter.
- Throughput is parametrised by how many columns are transformed per clock (1, 2 or 4), trading area against latency.
- Sits between the ShiftRows/InvShiftRows and AddRoundKey stages of the round datapath and uses a valid/ready handshake on both sides.

Parameters:
- COLS_PER_CYCLE, default 1: number of columns mixed per BUSY cycle. Legal values are 1, 2 or 4; any other value is an elaboration error.
- FIXED_MODE, default 2: 0 = always forward, 1 = always inverse, 2 = mode taken from in_inv at acceptance.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: input block valid.
- in_ready  out  1: engine can accept a block.
- in_inv  in  1: 1 = InvMixColumns, 0 = MixColumns. Sampled only at acceptance and ignored unless FIXED_MODE=2.
- in_state  in  128: input state.
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts the result.
- out_state  out  128: result state.
- busy  out  1: high in BUSY or DONE.

Behaviour:
- Byte mapping: s[r][c] = state[127-32c-8r -: 8]. Column c occupies [127-32c -: 32], with row 0 as the MSB byte. out_state uses the same mapping.
- Arithmetic: GF(2^8) with reduction polynomial 0x11B, using xtime-based constant multiplies; no generic multiplier.
- Forward matrix rows: {02,03,01,01}, each subsequent row rotated right by one.
- Inverse matrix rows: {0e,0b,0d,09}, each subsequent row rotated right by one.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch in_state into the working register and latch the mode; go to BUSY and clear the column counter col_idx to 0.
  - BUSY: each cycle, replace columns col_idx .. col_idx+COLS_PER_CYCLE-1 of the working register in place, then add COLS_PER_CYCLE to col_idx (2-bit width, wraps).
  - BUSY exit: the cycle that processes column 3 moves the FSM to DONE.
  - DONE: out_valid=1 and out_state = working register. When out_ready=1, go to IDLE. No new block is accepted in DONE.
- Latency: with acceptance at clock edge k, out_valid rises at edge k+4/COLS_PER_CYCLE. That is 4, 2 or 1 cycles.
- Throughput: one block per 4/COLS_PER_CYCLE + 2 cycles, given out_ready is held high.
- in_ready is 0 in BUSY and DONE. in_valid, in_inv and in_state are don't-care in those states and have no effect.
- out_state is stable while out_valid=1 and out_ready=0 (backpressure), for any number of cycles.
- Columns not yet processed are never altered. A column is transformed exactly once per block.
- Reset values (asynchronous, any state including mid-BUSY): FSM=IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, working register=0, col_idx=0, latched mode=0. The partial block is discarded.
- On the first edge after rst deasserts with in_valid=1, the block is accepted normally.
- Simultaneous out_ready in DONE and in_valid: the output is consumed and the FSM goes to IDLE. The input is accepted on the next cycle, not the same one.
- Combinational paths: out_valid and in_ready come from flops only. out_ready may drive only the DONE→IDLE transition.

Test Plan:
- Forward, COLS_PER_CYCLE=1:
  - Stimulus: in_state=db135345_f20a225c_01010101_2d26314c, in_inv=0.
  - Required: out_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8; out_valid rises exactly 4 cycles after acceptance.
- Inverse, COLS_PER_CYCLE=4:
  - Stimulus: in_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inv=1.
  - Required: out_state=db135345_f20a225c_01010101_2d26314c; latency 1 cycle.
- Round-trip, COLS_PER_CYCLE=2:
  - Stimulus: 1000 random states, each sent forward, with the result fed back inverse.
  - Required: the original state is recovered every time; latency is 2 cycles; c6c6c6c6 and d4d4d4d5 columns give c6c6c6c6 and d5d5d7d6 respectively.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_state.
  - Required: out_state unchanged, in_ready=0, no extra accept; a single out_ready pulse returns the FSM to IDLE.
- Reset mid-operation:
  - Stimulus: assert rst in the 2nd BUSY cycle (COLS_PER_CYCLE=1).
  - Required: out_valid=0, out_state=0 and in_ready=1 immediately (asynchronously); the next block produces a correct result with full latency.
- FIXED_MODE=1:
  - Stimulus: in_inv=0 with the column 8e4da1bc.
  - Required: output column db135345 (inverse applied regardless of in_inv).
